irq_ctrl_param: RTL and testbench

Parametrised interrupt controller, the successor to the fixed 8-source POKEY IRQ core. Each of NUM_SRC sources is either latched (edge/pulse, sticky until acknowledged or disabled) or level (pass-through), as selected by parameter. The block adds an explicit acknowledge path, per-source sticky overrun flags and a registered priority-encoded vector output next to the wired IRQ line. It sits between the timer/serial/keyboard blocks and the CPU bus register file.

---
 rtl/irq_ctrl_param.sv | 94 +++++++++
 tb/tb_irq_ctrl_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_param.sv
// Parametrised interrupt controller: per-source latched or level requests,
// enable mask, acknowledge path, sticky overrun flags, and a registered IRQ
// line with a priority-encoded source index (bit 0 = highest priority).
module irq_ctrl_param #(
  parameter int                  NUM_SRC    = 8,
  parameter logic [NUM_SRC-1:0]  LEVEL_MASK = '0,
  parameter int                  IDX_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               enWr,
  input  logic [NUM_SRC-1:0] Dw,
  input  logic               ackWr,
  input  logic [NUM_SRC-1:0] Dack,
  input  logic [NUM_SRC-1:0] set,
  output logic [NUM_SRC-1:0] Dr,
  output logic [NUM_SRC-1:0] ovrun,
  output logic               IRQ,
  output logic [IDX_W-1:0]   irqId,
  output logic               irqValid
);

  logic [NUM_SRC-1:0] en_mask;
  logic [NUM_SRC-1:0] status;
  logic [NUM_SRC-1:0] ovrun_r;
  logic               irq_r;
  logic [IDX_W-1:0]   id_r;

  logic [NUM_SRC-1:0] eff_en;
  logic [NUM_SRC-1:0] ack_vec;
  logic [NUM_SRC-1:0] nxt_status;
  logic [NUM_SRC-1:0] nxt_ovrun;
  logic [NUM_SRC-1:0] pend;
  logic [IDX_W-1:0]   pend_id;

  // Lowest set index wins; an empty vector encodes as 0.
  function automatic logic [IDX_W-1:0] prio_enc(input logic [NUM_SRC-1:0] p);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (p[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Next-state logic for status, overrun and the pending vector.
  always_comb begin
    eff_en     = enWr ? Dw : en_mask;
    ack_vec    = ackWr ? Dack : '0;
    nxt_status = '0;
    nxt_ovrun  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (LEVEL_MASK[i]) begin
        // Level sources track the request line; enable only gates IRQ.
        nxt_status[i] = set[i];
        nxt_ovrun[i]  = 1'b0;
      end else begin
        // Set beats a same-edge acknowledge; a disable clears everything.
        nxt_status[i] = eff_en[i] & (set[i] | (status[i] & ~ack_vec[i]));
        nxt_ovrun[i]  = eff_en[i] & ~ack_vec[i] &
                        (ovrun_r[i] | (set[i] & status[i]));
      end
    end
    // Pending uses pre-edge registers, giving IRQ one cycle of latency
    // behind the status readback.
    pend    = status & en_mask;
    pend_id = prio_enc(pend);
  end

  // State registers: hold on en=0, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_mask <= '0;
      status  <= '0;
      ovrun_r <= '0;
      irq_r   <= 1'b0;
      id_r    <= '0;
    end else if (en) begin
      if (enWr) en_mask <= Dw;
      status  <= nxt_status;
      ovrun_r <= nxt_ovrun;
      irq_r   <= |pend;
      id_r    <= pend_id;
    end
  end

  assign Dr       = status;
  assign ovrun    = ovrun_r;
  assign IRQ      = irq_r;
  assign irqValid = irq_r;
  assign irqId    = id_r;

endmodule

// File: tb/tb_irq_ctrl_param.sv
// Directed bench for irq_ctrl_param (8 sources, source 3 configured as level).
module tb_irq_ctrl_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       enWr;
  logic [7:0] Dw;
  logic       ackWr;
  logic [7:0] Dack;
  logic [7:0] set;
  logic [7:0] Dr;
  logic [7:0] ovrun;
  logic       IRQ;
  logic [2:0] irqId;
  logic       irqValid;

  int checks = 0;
  int errors = 0;

  irq_ctrl_param #(
    .NUM_SRC   (8),
    .LEVEL_MASK(8'h08),
    .IDX_W     (3)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .enWr    (enWr),
    .Dw      (Dw),
    .ackWr   (ackWr),
    .Dack    (Dack),
    .set     (set),
    .Dr      (Dr),
    .ovrun   (ovrun),
    .IRQ     (IRQ),
    .irqId   (irqId),
    .irqValid(irqValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs are changed and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enWr = 1'b0; Dw = '0; ackWr = 1'b0; Dack = '0; set = '0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    idle();
    #12;
    chk("rst_dr",    32'(Dr), 32'h00);
    chk("rst_ovrun", 32'(ovrun), 32'h00);
    chk("rst_irq",   32'(IRQ), 32'h0);
    chk("rst_id",    32'(irqId), 32'h0);
    chk("rst_vld",   32'(irqValid), 32'h0);
    rst = 1'b0;
    #3;

    // Basic latch, IRQ latency, acknowledge
    enWr = 1'b1; Dw = 8'h05; step(); idle();
    set = 8'h04; step(); idle();
    chk("t1_dr",   32'(Dr), 32'h04);
    chk("t1_irq0", 32'(IRQ), 32'h0);
    step();
    chk("t1_irq",  32'(IRQ), 32'h1);
    chk("t1_id",   32'(irqId), 32'h2);
    chk("t1_vld",  32'(irqValid), 32'h1);
    ackWr = 1'b1; Dack = 8'h04; step(); idle();
    chk("t1_ack_dr",  32'(Dr), 32'h00);
    chk("t1_ack_irq", 32'(IRQ), 32'h1);
    step();
    chk("t1_irq_off", 32'(IRQ), 32'h0);
    chk("t1_vld_off", 32'(irqValid), 32'h0);

    // Priority between sources 0 and 7
    enWr = 1'b1; Dw = 8'hFF; step(); idle();
    set = 8'h81; step(); idle();
    chk("t2_dr", 32'(Dr), 32'h81);
    step();
    chk("t2_id0",  32'(irqId), 32'h0);
    chk("t2_irq",  32'(IRQ), 32'h1);
    ackWr = 1'b1; Dack = 8'h01; step(); idle();
    chk("t2_dr80", 32'(Dr), 32'h80);
    step();
    chk("t2_id7",  32'(irqId), 32'h7);
    chk("t2_irq7", 32'(IRQ), 32'h1);
    ackWr = 1'b1; Dack = 8'h80; step(); idle();
    step();
    chk("t2_irq_off", 32'(IRQ), 32'h0);
    chk("t2_vld_off", 32'(irqValid), 32'h0);
    chk("t2_id_off",  32'(irqId), 32'h0);

    // Overrun and set-beats-ack
    enWr = 1'b1; Dw = 8'h40; step(); idle();
    set = 8'h40; step(); idle();
    chk("t3_ov_none", 32'(ovrun), 32'h00);
    step();
    set = 8'h40; step(); idle();
    chk("t3_ov",  32'(ovrun), 32'h40);
    chk("t3_dr",  32'(Dr), 32'h40);
    ackWr = 1'b1; Dack = 8'h40; set = 8'h40; step(); idle();
    chk("t3_sa_dr", 32'(Dr), 32'h40);
    chk("t3_sa_ov", 32'(ovrun), 32'h00);
    ackWr = 1'b1; Dack = 8'h40; step(); idle();
    step();
    chk("t3_clear_irq", 32'(IRQ), 32'h0);

    // Disable clears latched status and overrun on the same edge
    enWr = 1'b1; Dw = 8'h02; step(); idle();
    set = 8'h02; step(); idle();
    step();
    chk("t4_irq", 32'(IRQ), 32'h1);
    chk("t4_id",  32'(irqId), 32'h1);
    set = 8'h02; step(); idle();
    chk("t4_ov",  32'(ovrun), 32'h02);
    enWr = 1'b1; Dw = 8'h00; step(); idle();
    chk("t4_dis_dr",  32'(Dr), 32'h00);
    chk("t4_dis_ov",  32'(ovrun), 32'h00);
    chk("t4_dis_irq", 32'(IRQ), 32'h1);
    step();
    chk("t4_irq_off", 32'(IRQ), 32'h0);
    set = 8'h02; step(); idle();
    chk("t4_drop", 32'(Dr), 32'h00);

    // Level source 3
    set = 8'h08; step();
    chk("t5_dr",   32'(Dr), 32'h08);
    step();
    chk("t5_irq0", 32'(IRQ), 32'h0);
    enWr = 1'b1; Dw = 8'h08; step(); enWr = 1'b0; Dw = '0;
    chk("t5_irq_pre", 32'(IRQ), 32'h0);
    step();
    chk("t5_irq", 32'(IRQ), 32'h1);
    chk("t5_id",  32'(irqId), 32'h3);
    ackWr = 1'b1; Dack = 8'h08; step(); ackWr = 1'b0; Dack = '0;
    chk("t5_ack_dr", 32'(Dr), 32'h08);
    set = 8'h00; step();
    chk("t5_drop_dr",  32'(Dr), 32'h00);
    chk("t5_drop_irq", 32'(IRQ), 32'h1);
    step();
    chk("t5_irq_off", 32'(IRQ), 32'h0);
    chk("t5_ov",      32'(ovrun), 32'h00);

    // Clock-enable hold, then asynchronous reset
    enWr = 1'b1; Dw = 8'hFF; set = 8'h01; step(); idle();
    step();
    chk("t6_irq", 32'(IRQ), 32'h1);
    en = 1'b0; set = 8'hFF; ackWr = 1'b1; Dack = 8'hFF; enWr = 1'b1; Dw = 8'h00;
    step(); step();
    chk("t6_hold_dr",  32'(Dr), 32'h01);
    chk("t6_hold_irq", 32'(IRQ), 32'h1);
    chk("t6_hold_id",  32'(irqId), 32'h0);
    chk("t6_hold_ov",  32'(ovrun), 32'h00);
    idle(); en = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t6_ar_dr",  32'(Dr), 32'h00);
    chk("t6_ar_irq", 32'(IRQ), 32'h0);
    chk("t6_ar_vld", 32'(irqValid), 32'h0);
    #3 rst = 1'b0;
    set = 8'h01; step(); idle();
    chk("t6_post_dr", 32'(Dr), 32'h00);
    step();
    chk("t6_post_irq", 32'(IRQ), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
